regfile_write_scheduler: RTL and testbench

Scheduler for the register file's single write port and its pending-write state. It shares the write port between the in-order pipeline writeback and a multi-cycle long-latency unit (divider, memory loads). It keeps a per-register busy scoreboard for writes that are still in flight, and from that scoreboard raises the decode-stage stall. It sits between the writeback stage, the long-latency unit and `register_file`, and drives `register_file`'s `addr_write`/`in` directly.

---
 rtl/regfile_write_scheduler_pkg.sv | 17 +
 rtl/regfile_write_scheduler_result_skid_buffer.sv | 33 +++
 rtl/regfile_write_scheduler.sv | 127 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types for the register-file write scheduler: operand widths and
// the write-port source selector.
package regfile_write_scheduler_pkg;

    typedef logic [4:0]  RegAddress;
    typedef logic [31:0] Word;

    typedef enum logic [1:0] {
        WPS_NONE,
        WPS_WB,
        WPS_BUF,
        WPS_LU
    } WritePortSrc;

    localparam int unsigned NUM_REGS = 32;

endpackage

// File: rtl/regfile_write_scheduler_result_skid_buffer.sv
// One-entry result buffer holding a long-latency result that lost the
// write port to writeback; drains when the port is next free.
import regfile_write_scheduler_pkg::*;

module result_skid_buffer (
    input  logic      clk,
    input  logic      reset,
    input  logic      capture,
    input  RegAddress capture_rd,
    input  Word       capture_data,
    input  logic      drain,
    output logic      buf_valid,
    output RegAddress buf_rd,
    output Word       buf_data
);

    // Capture only happens while empty and drain only while full, so the
    // two never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_rd    <= capture_rd;
            buf_data  <= capture_data;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write-port arbiter, busy scoreboard and decode stall for the register file.
// Optional operand bypass from the committing result: REGFILE_SCHED_BYPASS_EN.
import regfile_write_scheduler_pkg::*;

module regfile_write_scheduler (
    input  logic      clk,
    input  logic      reset,
    input  RegAddress wb_rd,
    input  Word       wb_data,
    input  logic      issue_valid,
    input  RegAddress issue_rd,
    input  logic      lu_valid,
    input  RegAddress lu_rd,
    input  Word       lu_data,
    output logic      lu_ready,
    input  logic      query_valid,
    input  RegAddress query_rs1,
    input  RegAddress query_rs2,
    input  RegAddress query_rd,
    output logic      stall,
    output RegAddress rf_addr_write,
    output Word       rf_in,
    output logic      byp1_hit,
    output logic      byp2_hit,
    output Word       byp1_data,
    output Word       byp2_data
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_eff;

    logic        buf_valid;
    RegAddress   buf_rd;
    Word         buf_data;
    WritePortSrc src;
    logic        clear_en;
    logic        accept;
    logic        capture;

    assign lu_ready = !buf_valid && !reset;
    assign accept   = lu_valid && lu_ready;
    assign capture  = accept && (src == WPS_WB);
    assign clear_en = (src == WPS_BUF) || (src == WPS_LU);

    result_skid_buffer u_skid (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .capture_rd   (lu_rd),
        .capture_data (lu_data),
        .drain        (src == WPS_BUF),
        .buf_valid    (buf_valid),
        .buf_rd       (buf_rd),
        .buf_data     (buf_data)
    );

    always_comb begin
        src = WPS_NONE;
        if (!reset) begin
            if (wb_rd != '0)
                src = WPS_WB;
            else if (buf_valid)
                src = WPS_BUF;
            else if (lu_valid)
                src = WPS_LU;
        end
    end

    always_comb begin
        rf_addr_write = '0;
        rf_in         = '0;
        case (src)
            WPS_WB:  begin rf_addr_write = wb_rd;  rf_in = wb_data;  end
            WPS_BUF: begin rf_addr_write = buf_rd; rf_in = buf_data; end
            WPS_LU:  begin rf_addr_write = lu_rd;  rf_in = lu_data;  end
            default: begin rf_addr_write = '0;     rf_in = '0;       end
        endcase
    end

    // Set is applied after clear so an issue to the register being
    // committed this cycle leaves it busy.
    always_comb begin
        busy_next = busy;
        if (clear_en)
            busy_next[rf_addr_write] = 1'b0;
        if (issue_valid && issue_rd != '0)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        busy_eff = busy;
`ifdef REGFILE_SCHED_BYPASS_EN
        if (clear_en)
            busy_eff[rf_addr_write] = 1'b0;
`endif
        busy_eff[0] = 1'b0;
    end

    assign stall = !reset && query_valid &&
                   (busy_eff[query_rs1] || busy_eff[query_rs2] || busy_eff[query_rd]);

`ifdef REGFILE_SCHED_BYPASS_EN
    assign byp1_hit  = clear_en && query_rs1 != '0 && query_rs1 == rf_addr_write;
    assign byp2_hit  = clear_en && query_rs2 != '0 && query_rs2 == rf_addr_write;
    assign byp1_data = rf_in;
    assign byp2_data = rf_in;
`else
    assign byp1_hit  = 1'b0;
    assign byp2_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
            assert (!(issue_valid && issue_rd != '0 && busy_eff[issue_rd]));
            assert (!(accept && !busy[lu_rd]));
            assert (!(lu_valid && lu_rd == '0));
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler; expectations
// follow the REGFILE_SCHED_BYPASS_EN setting of the build.
import regfile_write_scheduler_pkg::*;

module tb_regfile_write_scheduler;

    logic      clk = 1'b0;
    logic      reset;
    RegAddress wb_rd;
    Word       wb_data;
    logic      issue_valid;
    RegAddress issue_rd;
    logic      lu_valid;
    RegAddress lu_rd;
    Word       lu_data;
    logic      lu_ready;
    logic      query_valid;
    RegAddress query_rs1, query_rs2, query_rd;
    logic      stall;
    RegAddress rf_addr_write;
    Word       rf_in;
    logic      byp1_hit, byp2_hit;
    Word       byp1_data, byp2_data;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_SCHED_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_write_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .lu_valid      (lu_valid),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .query_valid   (query_valid),
        .query_rs1     (query_rs1),
        .query_rs2     (query_rs2),
        .query_rd      (query_rd),
        .stall         (stall),
        .rf_addr_write (rf_addr_write),
        .rf_in         (rf_in),
        .byp1_hit      (byp1_hit),
        .byp2_hit      (byp2_hit),
        .byp1_data     (byp1_data),
        .byp2_data     (byp2_data)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 time
    // unit later, well before the next rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_rd = '0; wb_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        query_valid = 1'b0; query_rs1 = '0; query_rs2 = '0; query_rd = '0;
    endtask

    task automatic issue(input RegAddress rd);
        idle();
        issue_valid = 1'b1;
        issue_rd = rd;
        step();
        idle();
    endtask

    task automatic query(input RegAddress rs1, input RegAddress rs2, input RegAddress rd);
        query_valid = 1'b1;
        query_rs1 = rs1;
        query_rs2 = rs2;
        query_rd = rd;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        wb_rd = 5'd3; wb_data = 32'd11;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'd22;
        query(5'd4, 5'd0, 5'd0);
        checks++; if (rf_addr_write !== 5'd0) begin errors++;
            $display("FAIL reset_addr got %0d want 0", rf_addr_write); end
        checks++; if (lu_ready !== 1'b0) begin errors++;
            $display("FAIL reset_lu_ready got %b want 0", lu_ready); end
        checks++; if (stall !== 1'b0 || byp1_hit !== 1'b0) begin errors++;
            $display("FAIL reset_stall_byp got %b/%b want 0/0", stall, byp1_hit); end
        step();
        step();
        reset = 1'b0;
        idle();
        query(5'd4, 5'd5, 5'd31);
        checks++; if (lu_ready !== 1'b1 || rf_addr_write !== 5'd0 || stall !== 1'b0) begin errors++;
            $display("FAIL post_reset got ready=%b addr=%0d stall=%b want 1/0/0",
                     lu_ready, rf_addr_write, stall); end
    endtask

    task automatic test_direct_commit();
        issue(5'd5);
        query(5'd5, 5'd0, 5'd0);
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL issue_stall got %b want 1", stall); end
        query(5'd0, 5'd0, 5'd0);
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'd77;
        #1;
        checks++; if (rf_addr_write !== 5'd5 || rf_in !== 32'd77 || lu_ready !== 1'b1) begin errors++;
            $display("FAIL direct_commit got addr=%0d in=%0d ready=%b want 5/77/1",
                     rf_addr_write, rf_in, lu_ready); end
        step();
        idle();
        query(5'd5, 5'd0, 5'd0);
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL direct_cleared got %b want 0", stall); end
    endtask

    task automatic test_wb_priority();
        issue(5'd6);
        wb_rd = 5'd3; wb_data = 32'd4;
        lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'd9;
        #1;
        checks++; if (rf_addr_write !== 5'd3 || rf_in !== 32'd4 || lu_ready !== 1'b1) begin errors++;
            $display("FAIL wb_priority got addr=%0d in=%0d ready=%b want 3/4/1",
                     rf_addr_write, rf_in, lu_ready); end
        step();
        idle();
        query(5'd0, 5'd0, 5'd6);
        checks++; if (rf_addr_write !== 5'd6 || rf_in !== 32'd9 || lu_ready !== 1'b0) begin errors++;
            $display("FAIL buf_drain got addr=%0d in=%0d ready=%b want 6/9/0",
                     rf_addr_write, rf_in, lu_ready); end
        checks++; if (stall !== !BYP) begin errors++;
            $display("FAIL buf_drain_stall got %b want %b", stall, !BYP); end
        step();
        idle();
        query(5'd0, 5'd0, 5'd6);
        checks++; if (lu_ready !== 1'b1 || stall !== 1'b0 || rf_addr_write !== 5'd0) begin errors++;
            $display("FAIL after_drain got ready=%b stall=%b addr=%0d want 1/0/0",
                     lu_ready, stall, rf_addr_write); end
    endtask

    task automatic test_buffer_hold();
        issue(5'd6);
        wb_rd = 5'd3; wb_data = 32'd1;
        lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h55;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_rd = RegAddress'(10 + i);
            wb_data = 32'(100 + i);
            query(5'd0, 5'd0, 5'd6);
            checks++; if (lu_ready !== 1'b0 || stall !== 1'b1 ||
                          rf_addr_write !== RegAddress'(10 + i)) begin errors++;
                $display("FAIL hold_%0d got ready=%b stall=%b addr=%0d want 0/1/%0d",
                         i, lu_ready, stall, rf_addr_write, 10 + i); end
            step();
        end
        idle();
        #1;
        checks++; if (rf_addr_write !== 5'd6 || rf_in !== 32'h55) begin errors++;
            $display("FAIL hold_drain got addr=%0d in=%0h want 6/55", rf_addr_write, rf_in); end
        step();
        idle();
        query(5'd6, 5'd6, 5'd6);
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL hold_cleared got %b want 0", stall); end
    endtask

    task automatic test_x0();
        idle();
        query(5'd1, 5'd0, 5'd0);
        checks++; if (stall !== 1'b0 || rf_addr_write !== 5'd0) begin errors++;
            $display("FAIL x0_query got stall=%b addr=%0d want 0/0", stall, rf_addr_write); end
        issue(5'd0);
        query(5'd0, 5'd0, 5'd0);
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL x0_issue got %b want 0", stall); end
    endtask

    task automatic test_bypass();
        issue(5'd7);
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'd123;
        query(5'd7, 5'd7, 5'd0);
        checks++; if (stall !== !BYP) begin errors++;
            $display("FAIL byp_stall got %b want %b", stall, !BYP); end
        checks++; if (byp1_hit !== BYP || byp2_hit !== BYP) begin errors++;
            $display("FAIL byp_hit got %b/%b want %b", byp1_hit, byp2_hit, BYP); end
        checks++; if (byp1_data !== (BYP ? 32'd123 : 32'd0) ||
                      byp2_data !== (BYP ? 32'd123 : 32'd0)) begin errors++;
            $display("FAIL byp_data got %0d/%0d want %0d", byp1_data, byp2_data,
                     BYP ? 123 : 0); end
        step();
        idle();
        query(5'd7, 5'd0, 5'd0);
        checks++; if (stall !== 1'b0 || byp1_hit !== 1'b0) begin errors++;
            $display("FAIL byp_after got stall=%b hit=%b want 0/0", stall, byp1_hit); end
    endtask

    task automatic test_reset_mid();
        issue(5'd8);
        issue(5'd9);
        wb_rd = 5'd2; wb_data = 32'd5;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'd1;
        step();
        idle();
        reset = 1'b1;
        query(5'd8, 5'd9, 5'd0);
        checks++; if (rf_addr_write !== 5'd0 || lu_ready !== 1'b0 || stall !== 1'b0) begin errors++;
            $display("FAIL mid_reset_in got addr=%0d ready=%b stall=%b want 0/0/0",
                     rf_addr_write, lu_ready, stall); end
        step();
        reset = 1'b0;
        idle();
        query(5'd8, 5'd0, 5'd9);
        checks++; if (rf_addr_write !== 5'd0 || lu_ready !== 1'b1 || stall !== 1'b0) begin errors++;
            $display("FAIL mid_reset_out got addr=%0d ready=%b stall=%b want 0/1/0",
                     rf_addr_write, lu_ready, stall); end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_direct_commit();
        test_wb_priority();
        test_buffer_hold();
        test_x0();
        test_bypass();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
